// File: rtl/pid_sequencer_if.sv
// Control-loop bus between the error source / motor drive and the PID sequencer.
// The master supplies error and pedal status; the slave returns the drive refresh.
interface pid_sequencer_if;
  logic               not_pedaling;
  logic signed [12:0] error;
  logic        [11:0] drv_mag;
  logic               drv_vld;
  logic               busy;

  modport master (
    output not_pedaling,
    output error,
    input  drv_mag,
    input  drv_vld,
    input  busy
  );

  modport slave (
    input  not_pedaling,
    input  error,
    output drv_mag,
    output drv_vld,
    output busy
  );
endinterface

// File: rtl/pid_sequencer.sv
// Time-multiplexed PID engine: one update per 2^TICK_W cycles, sequenced over a
// single 14-bit accumulator (integrator, P, I, D, then output saturation).
module pid_sequencer #(
  parameter int TICK_W  = 20,
  parameter int D_DEPTH = 3
) (
  input  logic            clk,
  input  logic            rst,
  pid_sequencer_if.slave  bus
);

  localparam int HW = 13;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INTEG = 3'd1,
    I_ADD = 3'd2,
    D_ADD = 3'd3,
    SAT   = 3'd4
  } state_t;

  state_t                    state_reg, state_next;
  logic [TICK_W-1:0]         cnt_reg;
  logic                      tick;
  logic [17:0]               integ_reg, integ_next;
  logic [13:0]               acc_reg, acc_next;
  logic signed [12:0]        err_smp_reg, err_smp_next;
  logic [D_DEPTH*HW-1:0]     hist_reg, hist_next, hist_shift;
  logic                      np_flag_reg, np_flag_next;
  logic [11:0]               drv_mag_reg, drv_mag_next;
  logic                      drv_vld_reg, drv_vld_next;

  logic [17:0]               integ_sum;
  logic [13:0]               i_term;
  logic signed [12:0]        hist_old;
  logic signed [12:0]        d_diff;
  logic signed [8:0]         d_clip;
  logic [13:0]               d_term;

  assign tick = &cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + TICK_W'(1);
    end
  end

  assign integ_sum = integ_reg + {{5{err_smp_reg[12]}}, err_smp_reg};
  assign i_term    = {2'b00, integ_reg[16:5]};

  // Oldest stored sample feeds the D term; new sample enters at slot 0.
  assign hist_old = hist_reg[D_DEPTH*HW-1 -: HW];
  assign d_diff   = err_smp_reg - hist_old;

  genvar gi;
  generate
    for (gi = 0; gi < D_DEPTH; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        assign hist_shift[HW-1:0] = err_smp_reg;
      end else begin : g_tail
        assign hist_shift[gi*HW +: HW] = hist_reg[(gi-1)*HW +: HW];
      end
    end
  endgenerate

  always_comb begin
    d_clip = d_diff[8:0];
    if (d_diff > 13'sd255) begin
      d_clip = 9'h0FF;
    end else if (d_diff < -13'sd256) begin
      d_clip = 9'h100;
    end
  end

  assign d_term = {{3{d_clip[8]}}, d_clip, 2'b00};

  always_comb begin
    state_next   = state_reg;
    err_smp_next = err_smp_reg;
    integ_next   = integ_reg;
    acc_next     = acc_reg;
    hist_next    = hist_reg;
    np_flag_next = np_flag_reg;
    drv_mag_next = drv_mag_reg;
    drv_vld_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (tick) begin
          err_smp_next = bus.error;
          state_next   = INTEG;
        end
      end
      INTEG: begin
        np_flag_next = bus.not_pedaling;
        // Integrator is kept non-negative and clamped at 17 bits of magnitude.
        if (bus.not_pedaling) begin
          integ_next = '0;
        end else if (integ_sum[17] && !integ_sum[16]) begin
          integ_next = 18'h1FFFF;
        end else if (integ_sum[17]) begin
          integ_next = '0;
        end else begin
          integ_next = integ_sum;
        end
        acc_next   = {err_smp_reg[12], err_smp_reg};
        state_next = I_ADD;
      end
      I_ADD: begin
        acc_next   = acc_reg + i_term;
        state_next = D_ADD;
      end
      D_ADD: begin
        acc_next   = acc_reg + d_term;
        hist_next  = hist_shift;
        state_next = SAT;
      end
      SAT: begin
        if (np_flag_reg || acc_reg[13]) begin
          drv_mag_next = '0;
        end else if (acc_reg[12]) begin
          drv_mag_next = 12'hFFF;
        end else begin
          drv_mag_next = acc_reg[11:0];
        end
        drv_vld_next = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      err_smp_reg <= '0;
      integ_reg   <= '0;
      acc_reg     <= '0;
      hist_reg    <= '0;
      np_flag_reg <= 1'b0;
      drv_mag_reg <= '0;
      drv_vld_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      err_smp_reg <= err_smp_next;
      integ_reg   <= integ_next;
      acc_reg     <= acc_next;
      hist_reg    <= hist_next;
      np_flag_reg <= np_flag_next;
      drv_mag_reg <= drv_mag_next;
      drv_vld_reg <= drv_vld_next;
    end
  end

  assign bus.drv_mag = drv_mag_reg;
  assign bus.drv_vld = drv_vld_reg;
  assign bus.busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_pid_sequencer.sv
// Directed + randomized bench for pid_sequencer against an arithmetic PID model.
module tb_pid_sequencer;
  localparam int TICK_W  = 4;
  localparam int D_DEPTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pid_sequencer_if bus ();

  pid_sequencer #(.TICK_W(TICK_W), .D_DEPTH(D_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int m_integ;
  int m_hist [D_DEPTH];
  int upd_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic void model_reset();
    m_integ = 0;
    for (int i = 0; i < D_DEPTH; i++) m_hist[i] = 0;
  endfunction

  // One control update computed from the rules with plain integer arithmetic.
  function automatic int model_step(input int err, input bit np);
    int sum, d, acc;
    sum = m_integ + err;
    if (np)                m_integ = 0;
    else if (sum > 131071) m_integ = 131071;
    else if (sum < 0)      m_integ = 0;
    else                   m_integ = sum;
    d = err - m_hist[D_DEPTH-1];
    if (d > 255)  d = 255;
    if (d < -256) d = -256;
    d = d * 4;
    for (int k = D_DEPTH-1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = err;
    acc = err + (m_integ / 32) + d;
    if (np || acc < 0) return 0;
    if (acc > 4095)    return 4095;
    return acc;
  endfunction

  task automatic run_update(input int err, input bit np, input string tag, output int mag);
    int exp;
    bit seen;
    bus.error        = 13'(err);
    bus.not_pedaling = np;
    exp  = model_step(err, np);
    seen = 1'b0;
    upd_no++;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.drv_vld === 1'b1) seen = 1'b1;
    end
    check({tag, " vld_seen"}, 32'(seen), 32'd1);
    mag = int'(bus.drv_mag);
    check({tag, " drv_mag"}, 32'(bus.drv_mag), 32'(exp));
    check({tag, " busy_at_vld"}, 32'(bus.busy), 32'd0);
    $display("upd %0d %s: err=%0d np=%0d drv_mag=%0d expected=%0d", upd_no, tag, err, np, mag, exp);
    @(negedge clk);
    check({tag, " vld_one_cycle"}, 32'(bus.drv_vld), 32'd0);
    check({tag, " drv_mag_hold"}, 32'(bus.drv_mag), 32'(exp));
  endtask

  task automatic wait_busy(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) seen = 1'b1;
    end
    check({tag, " busy_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int mag, exp, err;
    bit np;

    bus.error        = '0;
    bus.not_pedaling = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset drv_mag", 32'(bus.drv_mag), 32'd0);
    check("reset drv_vld", 32'(bus.drv_vld), 32'd0);
    check("reset busy",    32'(bus.busy),    32'd0);

    // Release: tick at cycle 15, busy 16..19, drv_vld at 20.
    bus.error = 13'sd100;
    rst = 1'b0;
    exp = model_step(100, 1'b0);
    upd_no++;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      check($sformatf("latency busy c%0d", k), 32'(bus.busy), 32'((k >= 16 && k <= 19) ? 1 : 0));
      check($sformatf("latency vld c%0d", k), 32'(bus.drv_vld), 32'((k == 20) ? 1 : 0));
      if (k == 20) begin
        check("s2 u1 drv_mag", 32'(bus.drv_mag), 32'd503);
        $display("upd %0d s2 u1: err=100 np=0 drv_mag=%0d expected=%0d", upd_no, bus.drv_mag, exp);
      end
    end

    run_update(100, 1'b0, "s2 u2", mag);
    check("s2 u2 literal", 32'(mag), 32'd506);
    run_update(100, 1'b0, "s2 u3", mag);
    run_update(100, 1'b0, "s2 u4", mag);
    check("s2 u4 literal", 32'(mag), 32'd112);

    // Asynchronous reset while the FSM is mid-update.
    wait_busy("s1 midop");
    #2 rst = 1'b1;
    #1;
    check("async rst drv_mag", 32'(bus.drv_mag), 32'd0);
    check("async rst drv_vld", 32'(bus.drv_vld), 32'd0);
    check("async rst busy",    32'(bus.busy),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Positive saturation with full-scale error.
    for (int u = 1; u <= 36; u++) begin
      run_update(4095, 1'b0, $sformatf("s3 u%0d", u), mag);
      if (u >= 33) check($sformatf("s3 u%0d sat", u), 32'(mag), 32'd4095);
    end

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_reset();

    // Negative error from reset: integrator pinned at 0, output 0.
    for (int u = 1; u <= 4; u++) begin
      run_update(-200, 1'b0, $sformatf("s4 u%0d", u), mag);
      check($sformatf("s4 u%0d zero", u), 32'(mag), 32'd0);
    end
    run_update(100, 1'b0, "s4 step_up", mag);
    check("s4 step_up literal", 32'(mag), 32'd1123);
    run_update(-2000, 1'b0, "s4 step_down", mag);

    // Pedal stop and restart.
    for (int u = 1; u <= 3; u++) run_update(100, 1'b0, $sformatf("s5 u%0d", u), mag);
    run_update(100, 1'b1, "s5 stop", mag);
    check("s5 stop literal", 32'(mag), 32'd0);
    run_update(100, 1'b0, "s5 restart", mag);
    check("s5 restart literal", 32'(mag), 32'd103);

    // Reset landing in D_ADD clears history and integrator.
    wait_busy("s6");
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("s6 rst busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_update(100, 1'b0, "s6 after", mag);
    check("s6 after literal", 32'(mag), 32'd503);

    // Randomized updates against the model.
    for (int u = 1; u <= 30; u++) begin
      err = int'($urandom_range(4094)) - 2047;
      np  = ($urandom_range(7) == 0);
      run_update(err, np, $sformatf("rnd u%0d", u), mag);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
